frame_sequencer: RTL and testbench

APU frame sequencer: the scheduler that paces the envelope, sweep and length-counter units inside the APU. It runs on the APU clock and divides it into quarter-frame steps. It emits single-cycle quarter-frame and half-frame strobes in either 4-step or 5-step mode, and raises a frame interrupt at the end of each 4-step frame. It sits inside `apu`, between the serial register decoder (which supplies mode writes and interrupt acknowledges) and the channel units (which consume the strobes).

---
 rtl/frame_sequencer.sv | 77 +++++++
 tb/tb_frame_sequencer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/frame_sequencer.sv
// APU frame sequencer: divides the APU clock into quarter-frame steps and emits
// quarter/half-frame strobes plus the 4-step frame interrupt.
module frame_sequencer #(
  parameter int CLKRATE   = 2_000_000,
  parameter int FRAMERATE = 240,
  parameter int QUARTER   = CLKRATE / FRAMERATE
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cfg_we,
  input  logic [1:0] cfg_data,
  input  logic       irq_ack,
  output logic       quarter_frame,
  output logic       half_frame,
  output logic       irq,
  output logic [2:0] step
);

  localparam int CW = $clog2(QUARTER);
  localparam logic [CW-1:0] CNT_LAST = CW'(QUARTER - 1);

  logic [CW-1:0] cnt;
  logic          mode;     // 0 = 4-step, 1 = 5-step
  logic          inhibit;

  logic       terminal;
  logic       last_step;
  logic       ev_quarter;
  logic       ev_half;
  logic       ev_irq;

  // Step-end events decoded from the step that is finishing.
  always_comb begin
    terminal   = (cnt == CNT_LAST);
    last_step  = mode ? (step == 3'd4) : (step == 3'd3);
    ev_quarter = !(mode && step == 3'd3);
    ev_half    = (step == 3'd1) || (!mode && step == 3'd3) || (mode && step == 3'd4);
    ev_irq     = !mode && !inhibit && (step == 3'd3);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt           <= '0;
      step          <= '0;
      mode          <= 1'b0;
      inhibit       <= 1'b0;
      irq           <= 1'b0;
      quarter_frame <= 1'b0;
      half_frame    <= 1'b0;
    end else begin
      quarter_frame <= 1'b0;
      half_frame    <= 1'b0;
      if (irq_ack) irq <= 1'b0;
      if (cfg_we) begin
        // A write restarts the frame and discards any coincident terminal event.
        mode    <= cfg_data[1];
        inhibit <= cfg_data[0];
        cnt     <= '0;
        step    <= '0;
        if (cfg_data[1]) begin
          quarter_frame <= 1'b1;
          half_frame    <= 1'b1;
        end
        if (cfg_data[0]) irq <= 1'b0;
      end else if (terminal) begin
        cnt           <= '0;
        step          <= last_step ? 3'd0 : step + 3'd1;
        quarter_frame <= ev_quarter;
        half_frame    <= ev_half;
        if (ev_irq) irq <= 1'b1;  // set wins over a coincident ack
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_frame_sequencer.sv
// Directed bench for frame_sequencer with QUARTER = 10 (1000 Hz / 100 Hz).
module tb_frame_sequencer;

  logic       clk;
  logic       rst_n;
  logic       cfg_we;
  logic [1:0] cfg_data;
  logic       irq_ack;
  logic       quarter_frame;
  logic       half_frame;
  logic       irq;
  logic [2:0] step;

  int n_checks = 0;
  int n_fail   = 0;
  int edge_n   = 0;
  int q_cnt    = 0;
  int h_cnt    = 0;
  int irq_seen = 0;

  logic [2:0] exp_q[$];

  typedef struct {
    int         edge_n;
    logic       q;
    logic       h;
    logic       irq;
    logic [2:0] step;
  } vec_t;

  vec_t vecs[13];

  frame_sequencer #(.CLKRATE(1000), .FRAMERATE(100)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cfg_we        (cfg_we),
    .cfg_data      (cfg_data),
    .irq_ack       (irq_ack),
    .quarter_frame (quarter_frame),
    .half_frame    (half_frame),
    .irq           (irq),
    .step          (step)
  );

  // Clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @edge %0d: got %0h expected %0h", name, edge_n, act, exp);
    end
  endtask

  // One rising edge, then sample 1 time unit later; pulses and queued step checks.
  task automatic tick();
    @(posedge clk);
    #1;
    edge_n++;
    if (quarter_frame) q_cnt++;
    if (half_frame) h_cnt++;
    if (irq) irq_seen++;
    if (quarter_frame && exp_q.size() > 0) chk("step_seq", 32'(step), 32'(exp_q.pop_front()));
  endtask

  task automatic run_to(input int n);
    while (edge_n < n) tick();
  endtask

  task automatic clear_counts();
    q_cnt    = 0;
    h_cnt    = 0;
    irq_seen = 0;
  endtask

  // Reset held across two edges, released just after an edge; the next edge is edge 1.
  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n  = 1'b1;
    edge_n = 0;
    clear_counts();
  endtask

  task automatic chk_outs(input string name, input logic q, input logic h,
                          input logic i, input logic [2:0] s);
    chk({name, "_q"}, 32'(quarter_frame), 32'(q));
    chk({name, "_h"}, 32'(half_frame), 32'(h));
    chk({name, "_irq"}, 32'(irq), 32'(i));
    chk({name, "_step"}, 32'(step), 32'(s));
  endtask

  initial begin
    vecs[0]  = '{9,  1'b0, 1'b0, 1'b0, 3'd0};
    vecs[1]  = '{10, 1'b1, 1'b0, 1'b0, 3'd1};
    vecs[2]  = '{11, 1'b0, 1'b0, 1'b0, 3'd1};
    vecs[3]  = '{20, 1'b1, 1'b1, 1'b0, 3'd2};
    vecs[4]  = '{30, 1'b1, 1'b0, 1'b0, 3'd3};
    vecs[5]  = '{39, 1'b0, 1'b0, 1'b0, 3'd3};
    vecs[6]  = '{40, 1'b1, 1'b1, 1'b1, 3'd0};
    vecs[7]  = '{41, 1'b0, 1'b0, 1'b1, 3'd0};
    vecs[8]  = '{50, 1'b1, 1'b0, 1'b1, 3'd1};
    vecs[9]  = '{60, 1'b1, 1'b1, 1'b1, 3'd2};
    vecs[10] = '{70, 1'b1, 1'b0, 1'b1, 3'd3};
    vecs[11] = '{79, 1'b0, 1'b0, 1'b1, 3'd3};
    vecs[12] = '{80, 1'b1, 1'b1, 1'b1, 3'd0};

    rst_n    = 1'b0;
    cfg_we   = 1'b0;
    cfg_data = 2'b00;
    irq_ack  = 1'b0;
    #1;
    chk_outs("reset", 1'b0, 1'b0, 1'b0, 3'd0);

    // 4-step timing
    do_reset();
    exp_q = '{3'd1, 3'd2, 3'd3, 3'd0, 3'd1, 3'd2, 3'd3, 3'd0};
    foreach (vecs[i]) begin
      run_to(vecs[i].edge_n);
      chk_outs($sformatf("v4_%0d", vecs[i].edge_n), vecs[i].q, vecs[i].h, vecs[i].irq, vecs[i].step);
    end
    chk("v4_q_count", 32'(q_cnt), 32'd8);
    chk("v4_h_count", 32'(h_cnt), 32'd4);
    chk("v4_exp_q_drained", 32'(exp_q.size()), 32'd0);

    // 5-step mode: write 2'b10 on edge 5
    do_reset();
    run_to(4);
    cfg_we = 1'b1; cfg_data = 2'b10;
    run_to(5);
    cfg_we = 1'b0; cfg_data = 2'b00;
    chk_outs("m5_write", 1'b1, 1'b1, 1'b0, 3'd0);
    run_to(6);
    chk_outs("m5_after", 1'b0, 1'b0, 1'b0, 3'd0);
    clear_counts();
    run_to(15);  chk_outs("m5_s0", 1'b1, 1'b0, 1'b0, 3'd1);
    run_to(25);  chk_outs("m5_s1", 1'b1, 1'b1, 1'b0, 3'd2);
    run_to(35);  chk_outs("m5_s2", 1'b1, 1'b0, 1'b0, 3'd3);
    run_to(45);  chk_outs("m5_s3", 1'b0, 1'b0, 1'b0, 3'd4);
    run_to(55);  chk_outs("m5_s4", 1'b1, 1'b1, 1'b0, 3'd0);
    run_to(105); chk_outs("m5_s4b", 1'b1, 1'b1, 1'b0, 3'd0);
    chk("m5_q_count", 32'(q_cnt), 32'd8);
    chk("m5_h_count", 32'(h_cnt), 32'd4);
    chk("m5_irq_never", 32'(irq_seen), 32'd0);

    // IRQ ack, inhibit write, inhibited frame
    do_reset();
    run_to(40);
    chk("irq_set", 32'(irq), 32'd1);
    run_to(44);
    irq_ack = 1'b1;
    run_to(45);
    irq_ack = 1'b0;
    chk("irq_ack_clear", 32'(irq), 32'd0);
    run_to(80);
    chk("irq_set2", 32'(irq), 32'd1);
    cfg_we = 1'b1; cfg_data = 2'b01;
    run_to(81);
    cfg_we = 1'b0; cfg_data = 2'b00;
    chk_outs("inh_write", 1'b0, 1'b0, 1'b0, 3'd0);
    clear_counts();
    run_to(121);
    chk_outs("inh_frame", 1'b1, 1'b1, 1'b0, 3'd0);
    chk("inh_irq_never", 32'(irq_seen), 32'd0);

    // Set/ack collision on edge 40
    do_reset();
    run_to(39);
    irq_ack = 1'b1;
    run_to(40);
    irq_ack = 1'b0;
    chk("collide_irq", 32'(irq), 32'd1);

    // Write on the terminal cycle (cnt == 9), plus ack while clear
    do_reset();
    run_to(9);
    cfg_we = 1'b1; cfg_data = 2'b00;
    run_to(10);
    cfg_we = 1'b0;
    chk_outs("term_write", 1'b0, 1'b0, 1'b0, 3'd0);
    clear_counts();
    run_to(18);
    irq_ack = 1'b1;
    run_to(19);
    irq_ack = 1'b0;
    chk("term_no_early_q", 32'(q_cnt), 32'd0);
    chk("ack_while_clear", 32'(irq), 32'd0);
    run_to(20);
    chk_outs("term_next_q", 1'b1, 1'b0, 1'b0, 3'd1);

    // Held write in 5-step mode: strobes every cycle, step pinned at 0
    do_reset();
    run_to(3);
    cfg_we = 1'b1; cfg_data = 2'b10;
    clear_counts();
    run_to(7);
    cfg_we = 1'b0; cfg_data = 2'b00;
    chk("held_q_count", 32'(q_cnt), 32'd4);
    chk("held_h_count", 32'(h_cnt), 32'd4);
    run_to(16);
    chk_outs("held_next", 1'b0, 1'b0, 1'b0, 3'd0);
    run_to(17);
    chk_outs("held_next_q", 1'b1, 1'b0, 1'b0, 3'd1);

    // Asynchronous reset mid-step (edge 33) and mid-strobe (edge 40)
    do_reset();
    run_to(33);
    chk("mid_step_pre", 32'(step), 32'd3);
    rst_n = 1'b0;
    #1;
    chk_outs("mid_rst33", 1'b0, 1'b0, 1'b0, 3'd0);
    do_reset();
    run_to(40);
    rst_n = 1'b0;
    #1;
    chk_outs("mid_rst40", 1'b0, 1'b0, 1'b0, 3'd0);
    do_reset();
    run_to(9);
    chk("rst_no_early_q", 32'(q_cnt), 32'd0);
    run_to(10);
    chk_outs("rst_first_q", 1'b1, 1'b0, 1'b0, 3'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
